bus_capture_fifo: RTL and testbench

// - Downstream consumer of the 8-bit shared tri-state data bus driven by the

---
 rtl/bus_capture_fifo.sv | 117 +++++++++++
 tb/tb_bus_capture_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_capture_fifo.sv
// rtl/bus_capture_fifo.sv - arm-triggered tri-state bus burst sampler feeding a valid/ready FIFO
// Optional feature macro: BUS_PARITY_EN (per-entry even parity with par_err on the head)
module bus_capture_fifo #(
    parameter int DW        = 8,
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            bus_data,
    input  logic                     bus_oe_n,
    input  logic                     bus_sel,
    input  logic                     arm,
    input  logic                     clr_ovf,
    output logic [DW-1:0]            out_data,
    output logic                     out_src,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
`ifdef BUS_PARITY_EN
    output logic                     par_err,
`endif
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPT} state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_burst;
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [DW:0]     r_mem [DEPTH];

    logic            w_sample, w_last, w_full, w_pop, w_push;
    logic [DW:0]     w_head;

    assign w_sample = ((r_state == S_ARMED) || (r_state == S_CAPT)) && !bus_oe_n
                      && (r_burst < 8'(MAX_BURST));
    assign w_last   = w_sample && ((r_burst + 8'd1) == 8'(MAX_BURST));
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_pop    = (r_count != '0) && out_ready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign w_push   = w_sample && (!w_full || w_pop);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (arm) w_next = S_ARMED;
            S_ARMED: if (!bus_oe_n) w_next = w_last ? S_IDLE : S_CAPT;
            S_CAPT:  if (!w_sample || w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_burst    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && arm)
                r_burst <= '0;
            else if (w_sample)
                r_burst <= r_burst + 8'd1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_sample && w_full && !w_pop)
                r_overflow <= 1'b1;
            else if (clr_ovf)
                r_overflow <= 1'b0;
        end
    end

    // Storage needs no reset: every read is gated by a non-zero count.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {bus_sel, bus_data};
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? w_head[DW-1:0] : '0;
    assign out_src   = out_valid ? w_head[DW] : 1'b0;
    assign count     = r_count;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign busy      = (r_state != S_IDLE);

`ifdef BUS_PARITY_EN
    logic [DEPTH-1:0] r_par;

    always_ff @(posedge clk) begin
        if (w_push)
            r_par[r_wr_ptr] <= ^bus_data;
    end

    assign par_err = out_valid && (r_par[r_rd_ptr] != ^out_data);
`endif

endmodule

// File: tb/tb_bus_capture_fifo.sv
// tb/tb_bus_capture_fifo.sv - self-checking bench for bus_capture_fifo
module tb_bus_capture_fifo;

    localparam int DW        = 8;
    localparam int DEPTH     = 8;
    localparam int MAX_BURST = 4;

    logic          clk = 1'b0;
    logic          rst, bus_oe_n, bus_sel, arm, clr_ovf, out_ready;
    logic [DW-1:0] bus_data;
    logic [DW-1:0] out_data;
    logic          out_src, out_valid, full, overflow, busy;
    logic [3:0]    count;
`ifdef BUS_PARITY_EN
    logic          par_err;
`endif

    bus_capture_fifo #(.DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .bus_data(bus_data), .bus_oe_n(bus_oe_n),
        .bus_sel(bus_sel), .arm(arm), .clr_ovf(clr_ovf),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .full(full), .overflow(overflow),
`ifdef BUS_PARITY_EN
        .par_err(par_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n_drive;
        logic [7:0]  base;
        logic [7:0]  step;
        logic [31:0] sel_pat;
        bit          drain;
        int          exp_count;
        bit          exp_ovf;
    } vec_t;

    vec_t       vt[5];
    logic [8:0] expq[$];
    int         mcount;
    bit         exp_ovf;
    int         n_checks;
    int         n_errors;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input int n, input logic [7:0] base, input logic [7:0] step,
                             input logic [31:0] selp);
        logic [7:0] d;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("armed_busy", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            d        = 8'(base + 8'(step * 8'(i)));
            bus_oe_n = 1'b0;
            bus_data = d;
            bus_sel  = selp[i];
            if (i < MAX_BURST) begin
                if (mcount < DEPTH) begin
                    expq.push_back({selp[i], d});
                    mcount++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            tick();
            chk("burst_busy", 32'(busy), 32'(i + 1 < MAX_BURST));
        end
        bus_oe_n = 1'b1;
        tick();
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_count", 32'(count), 32'(mcount));
        chk("post_ovf", 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic drain();
        logic [8:0] e;
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (expq.size() > 0 && guard < 40) begin
            guard++;
            chk("drain_valid", 32'(out_valid), 32'd1);
            if (!out_valid) break;
            e = expq.pop_front();
            chk("drain_data", 32'(out_data), 32'(e[7:0]));
            chk("drain_src", 32'(out_src), 32'(e[8]));
            mcount--;
            tick();
        end
        out_ready = 1'b0;
        chk("drained_queue", 32'(expq.size()), 32'd0);
        expq.delete();
        mcount = 0;
        chk("drained_valid", 32'(out_valid), 32'd0);
        chk("drained_count", 32'(count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [8:0] e;
        n_checks = 0; n_errors = 0; mcount = 0; exp_ovf = 1'b0;
        vt[0] = '{3,  8'h11, 8'h11, 32'b010,  1'b1, 3, 1'b0};
        vt[1] = '{10, 8'hA0, 8'h01, 32'b0,    1'b1, 4, 1'b0};
        vt[2] = '{4,  8'hB0, 8'h01, 32'b0101, 1'b0, 4, 1'b0};
        vt[3] = '{4,  8'hB4, 8'h01, 32'b1010, 1'b0, 8, 1'b0};
        vt[4] = '{4,  8'hC0, 8'h01, 32'hF,    1'b0, 8, 1'b1};

        rst = 1'b1; bus_oe_n = 1'b0; arm = 1'b1; bus_sel = 1'b1; bus_data = 8'hFF;
        clr_ovf = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        rst = 1'b0; arm = 1'b0; bus_oe_n = 1'b1; out_ready = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            run_burst(vt[v].n_drive, vt[v].base, vt[v].step, vt[v].sel_pat);
            chk("tbl_count", 32'(count), 32'(vt[v].exp_count));
            chk("tbl_ovf", 32'(overflow), 32'(vt[v].exp_ovf));
            if (vt[v].drain) drain();
        end

        chk("full_flag", 32'(full), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);

        arm = 1'b1;
        tick();
        arm = 1'b0;
        bus_oe_n = 1'b0; bus_data = 8'hC7; bus_sel = 1'b1; out_ready = 1'b1;
        chk("pp_valid", 32'(out_valid), 32'd1);
        e = expq.pop_front();
        chk("pp_head", 32'(out_data), 32'(e[7:0]));
        expq.push_back({1'b1, 8'hC7});
        tick();
        bus_oe_n = 1'b1; out_ready = 1'b0;
        chk("pp_count", 32'(count), 32'd8);
        chk("pp_full", 32'(full), 32'd1);
        chk("pp_ovf", 32'(overflow), 32'd0);
        tick();
        chk("pp_idle", 32'(busy), 32'd0);
        drain();

        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_oe_n = 1'b0; bus_data = 8'(8'h60 + 8'(i)); bus_sel = 1'b0;
            if (i == 2) rst = 1'b1;
            tick();
        end
        rst = 1'b0; bus_oe_n = 1'b1;
        expq.delete(); mcount = 0; exp_ovf = 1'b0;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);

        run_burst(4, 8'h10, 8'h01, 32'b0011);
        run_burst(4, 8'h20, 8'h01, 32'b1100);
        drain();
        run_burst(4, 8'h30, 8'h03, 32'b0110);
        drain();

`ifdef BUS_PARITY_EN
        run_burst(1, 8'h5A, 8'h00, 32'b0);
        chk("par_clean", 32'(par_err), 32'd0);
        force dut.r_par = 8'hFF;
        #1;
        chk("par_corrupt", 32'(par_err), 32'd1);
        release dut.r_par;
        drain();
        chk("par_empty", 32'(par_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
